// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit.
// funct3 load/store sizes and the access FSM states.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (f3 == F3_H),
      (f3 == F3_HU): m = lo[0];
      (f3 == F3_W):  m = |lo;
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data extension: sign/zero extends the low
// byte/half of a right-aligned word per funct3.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // mask and extend; upper raw bits are never trusted
  always_comb begin
    data = raw;
    unique case (funct3)
      F3_B:  data = {{24{raw[7]}}, raw[7:0]};
      F3_BU: data = {24'd0, raw[7:0]};
      F3_H:  data = {{16{raw[15]}}, raw[15:0]};
      F3_HU: data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator on the data BRAM port: one load/store
// per handshake, fixed-latency response with error flag.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W        = 11,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [31:0]       mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout
);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        req_err;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] ext;

  assign accept = req_valid && req_ready;

  // classify the incoming request as a fault
  always_comb begin
    req_err = 1'b0;
    if (|req_addr[31:ADDR_W])
      req_err = 1'b1;
    if (!f3_legal(req_funct3))
      req_err = 1'b1;
    if (MISALIGN_TRAP &&
        f3_misaligned(req_funct3, req_addr[1:0]))
      req_err = 1'b1;
  end

  mem_access_unit_load_extend u_ext (
    .funct3 (f3_q),
    .raw    (mem_dout),
    .data   (ext)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // next-state: faults skip the BRAM entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = req_err ? RESP : ISSUE;
      end
      ISSUE: state_d = wr_q ? RESP : WAIT;
      WAIT:  state_d = RESP;
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // handshake and write strobe decoded from state
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_write  = (state_q == ISSUE) && wr_q;
  end

  // request capture and load data return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      f3_q       <= 3'd0;
      mem_funct3 <= 3'd0;
      mem_din    <= 32'd0;
      mem_addr   <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_err   <= req_err;
      resp_rdata <= 32'd0;
      if (!req_err) begin
        wr_q       <= req_write;
        f3_q       <= req_funct3;
        mem_funct3 <= req_funct3 & 3'b011;
        mem_din    <= req_wdata;
        mem_addr   <= req_addr[ADDR_W-1:0];
      end
    end else if (state_q == WAIT) begin
      resp_rdata <= ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random bench for mem_access_unit
// against a byte-array memory reference model.
module tb_mem_access_unit;

  localparam int AW = 11;
  localparam int MSZ = 2048;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_write;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_din;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;

  int tests = 0;
  int fails = 0;

  logic [7:0] bram [MSZ];
  logic [7:0] ref_mem [MSZ];

  mem_access_unit #(
    .ADDR_W        (AW),
    .MISALIGN_TRAP (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_din    (mem_din),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM: sized byte-lane writes, registered
  // right-aligned 4-byte read from the address
  always @(posedge clk) begin
    logic [AW-1:0] a;
    int n;
    n = (mem_funct3[1:0] == 2'd0) ? 1 :
        (mem_funct3[1:0] == 2'd1) ? 2 : 4;
    if (mem_write)
      for (int k = 0; k < n; k++) begin
        a = mem_addr + AW'(k);
        bram[a] <= mem_din[8*k +: 8];
      end
    mem_dout <= {bram[mem_addr + AW'(3)],
                 bram[mem_addr + AW'(2)],
                 bram[mem_addr + AW'(1)],
                 bram[mem_addr]};
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic ref_model(input  logic        wr,
                           input  logic [2:0]  f3,
                           input  logic [31:0] addr,
                           input  logic [31:0] wd,
                           output logic        err,
                           output logic [31:0] rd,
                           output int          lat);
    int sz;
    longint v;
    int b [4];
    err = 0;
    if (addr >= MSZ) err = 1;
    if (f3 == 3 || f3 == 6 || f3 == 7) err = 1;
    if ((f3 == 1 || f3 == 5) && addr % 2 != 0)
      err = 1;
    if (f3 == 2 && addr % 4 != 0) err = 1;
    rd = 0;
    if (err) begin
      lat = 1;
      return;
    end
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (wr) begin
      lat = 2;
      for (int k = 0; k < sz; k++)
        ref_mem[(addr + k) % MSZ] =
          8'((wd >> (8 * k)) % 256);
      return;
    end
    lat = 3;
    for (int k = 0; k < 4; k++)
      b[k] = int'(ref_mem[(addr + k) % MSZ]);
    case (f3)
      0: v = (b[0] >= 128) ? b[0] - 256 : b[0];
      4: v = b[0];
      1: begin
        v = b[0] + 256 * b[1];
        if (v >= 32768) v = v - 65536;
      end
      5: v = b[0] + 256 * b[1];
      default:
        v = b[0] + 256 * b[1] + 65536 * b[2] +
            16777216 * longint'(b[3]);
    endcase
    rd = 32'(v);
  endtask

  task automatic scramble_req(input logic vld);
    req_valid  = vld;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // starts at clk+1 with the unit idle
  task automatic do_req(input logic        wr,
                        input logic [2:0]  f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int          hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          cyc;
    int          wcnt;
    logic [31:0] rd0;
    logic        er0;
    ref_model(wr, f3, addr, wd, e_err, e_rd, e_lat);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    scramble_req(1'b0);
    cyc  = 0;
    wcnt = 0;
    while (!resp_valid && cyc < 8) begin
      if (mem_write) begin
        wcnt++;
        check("mem_addr", mem_addr, addr % MSZ);
        check("mem_din", mem_din, wd);
        check("mem_funct3", mem_funct3, f3 % 4);
      end
      scramble_req(1'($urandom));
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    check("resp_timeout", 32'(cyc < 8), 1);
    check("latency", cyc + 1, e_lat);
    check("write_pulses", wcnt,
          (wr && !e_err) ? 1 : 0);
    check("resp_err", resp_err, e_err);
    check("resp_rdata", resp_rdata, e_rd);
    rd0 = resp_rdata;
    er0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      scramble_req(1'($urandom));
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, rd0);
      check("hold_err", resp_err, er0);
      check("hold_rdy", req_ready, 0);
      check("hold_wr", mem_write, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("rel_valid", resp_valid, 0);
    check("rel_ready", req_ready, 1);
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_req_ready"}, req_ready, 1);
    check({t, "_resp_valid"}, resp_valid, 0);
    check({t, "_resp_rdata"}, resp_rdata, 0);
    check({t, "_resp_err"}, resp_err, 0);
    check({t, "_mem_write"}, mem_write, 0);
    check({t, "_mem_funct3"}, mem_funct3, 0);
    check({t, "_mem_din"}, mem_din, 0);
    check({t, "_mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    reset_n    = 1'b0;
    resp_ready = 1'b0;
    scramble_req(1'b0);
    for (int i = 0; i < MSZ; i++) begin
      bram[i]    = 8'($urandom);
      ref_mem[i] = bram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    do_req(1, 3'd0, 32'h21, 32'h00000080, 0);
    do_req(0, 3'd0, 32'h21, 32'h0, 0);
    do_req(0, 3'd4, 32'h21, 32'h0, 0);
    do_req(1, 3'd2, 32'h40, 32'h1234F00D, 0);
    do_req(0, 3'd1, 32'h40, 32'h0, 0);
    do_req(0, 3'd5, 32'h40, 32'h0, 0);
    do_req(0, 3'd2, 32'h40, 32'h0, 0);
    do_req(0, 3'd2, 32'h10, 32'h0, 1);
    do_req(0, 3'd2, 32'h802, 32'h0, 0);
    do_req(1, 3'd3, 32'h0, 32'h55, 0);
    do_req(0, 3'd1, 32'h11, 32'h0, 0);
    do_req(1, 3'd2, 32'h2, 32'hAAAA5555, 0);
    do_req(0, 3'd2, 32'h40, 32'h0, 5);

    // reset asserted between edges while in WAIT
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_pre_rst", resp_valid, 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", resp_valid, 0);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom % 16);
      case (r % 5)
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      if (r >= 14) f3 = 3'(3 + 3 * ($urandom % 2));
      if (r == 15 && $urandom % 2 == 1) f3 = 3'd7;
      r = int'($urandom % 16);
      if (r == 0)
        a = $urandom;
      else
        a = $urandom % MSZ;
      if (r >= 1 && r < 10 && f3 % 4 == 1)
        a = a & ~32'd1;
      if (r >= 1 && r < 10 && f3 % 4 == 2)
        a = a & ~32'd3;
      do_req(1'($urandom), f3, a, $urandom,
             int'($urandom % 3));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
